// File: rtl/sysu_bcd_down_timer_if.sv
// Control/data bundle between a sysu_bcd_down_timer and the logic that drives it.
// The controller uses modport master and the timer uses modport slave.
interface sysu_bcd_down_timer_if #(
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned W = 4 * DIGITS;

    logic         PE_N;
    logic         CET;
    logic         CEP;
    logic [W-1:0] P;
    logic [W-1:0] Q;
    logic         TC;
    logic         RUN;
    logic         DONE;

    modport master (
        output PE_N, CET, CEP, P,
        input  Q, TC, RUN, DONE
    );

    modport slave (
        input  PE_N, CET, CEP, P,
        output Q, TC, RUN, DONE
    );
endinterface

// File: rtl/sysu_bcd_down_timer.sv
// Multi-digit BCD down-counter/timer with a one-cycle DONE pulse and a lookahead TC.
// Defining SYSU_BCD_TIMER_AUTO_RELOAD_EN makes expiry reload the last preset and keep running.
module sysu_bcd_down_timer #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  CP,
    input  logic                  MR,
    sysu_bcd_down_timer_if.slave  tmr
);
    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] reload_q, reload_d;
    logic         run_q, done_q;
    logic [W-1:0] p_san;
    logic         at_one;

    // Clamp every non-decimal digit (10..15) to 9.
    function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple-borrow BCD decrement; never called with an all-zero value.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign p_san  = bcd_sanitize(tmr.P);
    assign at_one = (q_q == W'(1));

    // Load beats count beats hold; MR is applied in the register block.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        if (!tmr.PE_N) begin
            q_d      = p_san;
            reload_d = p_san;
            state_d  = (p_san != '0) ? ST_RUN : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (tmr.CET && tmr.CEP) begin
                        if (at_one) begin
`ifdef SYSU_BCD_TIMER_AUTO_RELOAD_EN
                            q_d = reload_q;
`else
                            q_d = '0;
`endif
                            state_d = ST_DONE;
                        end else begin
                            q_d = bcd_dec(q_q);
                        end
                    end
                end
                ST_DONE: begin
`ifdef SYSU_BCD_TIMER_AUTO_RELOAD_EN
                    state_d = ST_RUN;
`else
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            reload_q <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            run_q    <= (state_d == ST_RUN);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign tmr.Q    = q_q;
    assign tmr.RUN  = run_q;
    assign tmr.DONE = done_q;
    assign tmr.TC   = tmr.CET & run_q & at_one;

endmodule
